// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic register chain with per-slot hold, per-slot flush and debug statistics.
// Optional feature macro: PIPE_FLUSH_EN (flush_mask is honoured only when it is defined).
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  input  logic [STAGES-1:0]             hold,
  input  logic [STAGES-1:0]             flush_mask,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int OCC_W = $clog2(STAGES+1);

  // Handshake: a beat transfers on any edge where valid && ready are both high;
  // ready never depends on the valid of the same interface.
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] valid_nxt;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] go;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  data [STAGES];
  logic [OCC_W-1:0]  occ_nxt;

`ifdef PIPE_FLUSH_EN
  assign kill = flush_mask;
`else
  logic unused_flush;
  assign kill         = '0;
  assign unused_flush = ^flush_mask;
`endif

  // Readiness ripples from the output back toward the input.
  always_comb begin
    logic down_rdy;
    go       = '0;
    rdy      = '0;
    down_rdy = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go[k]    = valid[k] && !kill[k] && !hold[k] && down_rdy;
      rdy[k]   = !valid[k] || kill[k] || go[k];
      down_rdy = rdy[k];
    end
  end

  // load[k] already implies rdy[k]; a ready slot with nothing arriving empties.
  always_comb begin
    load      = '0;
    valid_nxt = valid;
    occ_nxt   = '0;
    load[0]   = in_valid && rdy[0];
    for (int k = 1; k < STAGES; k++) load[k] = go[k-1];
    for (int k = 0; k < STAGES; k++) begin
      if (rdy[k]) valid_nxt[k] = load[k];
    end
    for (int k = 0; k < STAGES; k++) occ_nxt = occ_nxt + OCC_W'(valid_nxt[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid     <= '0;
      occupancy <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < STAGES; k++) data[k] <= '0;
    end else begin
      valid     <= valid_nxt;
      occupancy <= occ_nxt;
      if (in_valid && !rdy[0] && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (load[0]) data[0] <= in_data;
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) data[k] <= data[k-1];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid[STAGES-1] && !kill[STAGES-1] && !hold[STAGES-1];
  assign out_data  = data[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed phases plus random traffic against a slot-level model.
module tb_pipe_stage_chain;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int CNT_W  = 6;
  localparam int OCC_W  = $clog2(STAGES+1);
  localparam int SAT    = (1 << CNT_W) - 1;
`ifdef PIPE_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] flush_mask;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .hold(hold),
    .flush_mask(flush_mask), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_pop = 0;
  int first_acc = -1;
  int first_out = -1;
  bit last_acc;
  logic [WIDTH-1:0] exp_q[$];

  // Model: each slot is either empty or holds a beat; data persists when a slot empties.
  bit               m_vld[STAGES];
  logic [WIDTH-1:0] m_dat[STAGES];
  int               m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < STAGES; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = '0;
    end
    m_stall = 0;
    exp_q.delete();
  endtask

  function automatic int model_occ();
    int n = 0;
    for (int k = 0; k < STAGES; k++) n += m_vld[k];
    return n;
  endfunction

  // One clock: inputs are already driven; compare combinational outputs, advance model, compare registers.
  task automatic cycle();
    bit kill[STAGES];
    bit go[STAGES];
    bit rdy[STAGES];
    bit down;
    bit pop;
    int idx;
    logic [WIDTH-1:0] nd[STAGES];
    bit nv[STAGES];
    #1;
    for (int k = 0; k < STAGES; k++) kill[k] = FLUSH_EN && flush_mask[k];
    down = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go[k]  = m_vld[k] && !kill[k] && !hold[k] && down;
      rdy[k] = !m_vld[k] || kill[k] || go[k];
      down   = rdy[k];
    end
    last_acc = in_valid && rdy[0];
    pop      = go[STAGES-1];
    check("in_ready", in_ready, rdy[0]);
    check("out_valid", out_valid, m_vld[STAGES-1] && !kill[STAGES-1] && !hold[STAGES-1]);
    check("out_data_driven", out_data, m_dat[STAGES-1]);
    if (pop) begin
      check("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("out_beat_order", out_data, exp_q.pop_front());
      n_pop++;
      if (first_out < 0) first_out = cyc;
    end
    // Killed beats must never reach the output: drop them from the expected stream.
    for (int k = 0; k < STAGES; k++) begin
      if (m_vld[k] && kill[k]) begin
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) if (idx < 0 && exp_q[i] == m_dat[k]) idx = i;
        if (idx >= 0) exp_q.delete(idx);
      end
    end
    if (last_acc) begin
      exp_q.push_back(in_data);
      if (first_acc < 0) first_acc = cyc;
    end
    if (in_valid && !rdy[0] && m_stall < SAT) m_stall++;
    for (int k = 0; k < STAGES; k++) begin
      nv[k] = m_vld[k];
      nd[k] = m_dat[k];
      if (rdy[k]) begin
        if (k == 0) begin
          nv[k] = last_acc;
          if (last_acc) nd[k] = in_data;
        end else begin
          nv[k] = go[k-1];
          if (go[k-1]) nd[k] = m_dat[k-1];
        end
      end
    end
    for (int k = 0; k < STAGES; k++) begin
      m_vld[k] = nv[k];
      m_dat[k] = nd[k];
    end
    @(posedge clk);
    #1;
    cyc++;
    check("occupancy", occupancy, model_occ());
    check("stall_cnt", stall_cnt, m_stall);
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    hold       = '0;
    flush_mask = '0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hold      = '0;
    flush_mask = '0;
    while (model_occ() > 0 && t < budget) begin
      cycle();
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Offer a beat until it is accepted or the budget runs out.
  task automatic push_beat(input logic [WIDTH-1:0] d, input int budget);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    last_acc = 1'b0;
    while (!last_acc && t < budget) begin
      cycle();
      t++;
    end
    check("push_accepted", last_acc, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    int s0;
    int idx;
    int t;
    int pops0;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b1;

    // Streaming 0x1..0x10 back-to-back.
    first_acc = -1;
    first_out = -1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      cycle();
      if (i == 8) check("occ_steady", occupancy, STAGES);
    end
    check("stream_latency", first_out - first_acc, STAGES);
    drain(20);

    // Back-pressure: fill, then 5 blocked cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + WIDTH'(i);
      cycle();
    end
    check("bp_full", occupancy, STAGES);
    s0 = m_stall;
    in_data = 32'hA4;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_in_ready_low", in_ready, 0);
    end
    check("bp_stall_delta", stall_cnt, s0 + 5);
    out_ready = 1'b1;
    push_beat(32'hA4, 10);
    drain(20);

    // Hold on slot 1 for two cycles mid-stream.
    idx = 0;
    t = 0;
    while (idx < 10 && t < 40) begin
      in_valid = 1'b1;
      in_data  = 32'hC0 + WIDTH'(idx);
      hold     = (t == 5 || t == 6) ? STAGES'(2) : '0;
      cycle();
      if (last_acc) idx++;
      t++;
    end
    check("hold_all_fed", idx, 10);
    hold = '0;
    drain(20);

    // Flush slots 0..2 while accepting B4.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hB0 + WIDTH'(i);
      cycle();
    end
    pops0 = n_pop;
    in_data    = 32'hB4;
    flush_mask = 4'b0111;
    cycle();
    flush_mask = '0;
    check("flush_occupancy", occupancy, FLUSH_EN ? 2 : 4);
    out_ready = 1'b1;
    if (!last_acc) push_beat(32'hB4, 10);
    drain(20);
    check("flush_emitted", n_pop - pops0, FLUSH_EN ? 2 : 5);

    // Random traffic with unique tagged payloads.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = {16'($urandom), 16'(i)};
      out_ready  = ($urandom_range(0, 3) != 0);
      hold       = ($urandom_range(0, 5) == 0) ? STAGES'($urandom) : '0;
      flush_mask = ($urandom_range(0, 9) == 0) ? STAGES'($urandom) : '0;
      cycle();
    end
    flush_mask = '0;
    drain(30);

    // Stall counter saturation.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < SAT + 10; i++) begin
      in_data = 32'hD000 + WIDTH'(i);
      cycle();
    end
    check("stall_saturated", stall_cnt, SAT);
    drain(20);

    // Asynchronous reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hE0 + WIDTH'(i);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_out_valid", out_valid, 0);
    check("async_occupancy", occupancy, 0);
    check("async_in_ready", in_ready, 1);
    check("async_stall_cnt", stall_cnt, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hF0 + WIDTH'(i);
      cycle();
    end
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
